if_fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC, drives the instruction-memory request/acknowledge handshake, and produces pc_plus_4 and instruction for the IF/ID pipeline register.
- Obeys the same stall and flush signals that IF/ID receives from the hazard and branch logic.
- Emits a NOP (all-zero word) whenever no valid instruction is available, so slow memory inserts bubbles.

---
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 tb/tb_if_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds IF/ID.
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_wait_cnt outputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] instruction_out,
    output logic        fetch_valid,
    output logic [31:0] pc_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_instr, hold_nxt;
    logic [31:0] redirect_pc, redirect_nxt;
    logic        req_c;
    logic        valid_c;
    logic [31:0] instr_c;

    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            hold_instr  <= 32'h0;
            redirect_pc <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            hold_instr  <= hold_nxt;
            redirect_pc <= redirect_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        hold_nxt     = hold_instr;
        redirect_nxt = redirect_pc;
        req_c        = 1'b0;
        valid_c      = 1'b0;
        instr_c      = 32'h0;
        case (state)
            FETCH: begin
                req_c = 1'b1;
                if (flush) begin
                    // Without an ack the request must finish at the old address first.
                    if (imem_ack) begin
                        pc_nxt = word_align(branch_target);
                    end else begin
                        redirect_nxt = word_align(branch_target);
                        state_nxt    = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (stall) begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        valid_c = 1'b1;
                        instr_c = imem_rdata;
                        pc_nxt  = pc_inc(pc);
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    hold_nxt  = 32'h0;
                    pc_nxt    = word_align(branch_target);
                    state_nxt = FETCH;
                end else if (!stall) begin
                    valid_c   = 1'b1;
                    instr_c   = hold_instr;
                    pc_nxt    = pc_inc(pc);
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    pc_nxt    = flush ? word_align(branch_target) : redirect_pc;
                    state_nxt = FETCH;
                end else if (flush) begin
                    redirect_nxt = word_align(branch_target);
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Every output is gated low while reset is held.
    assign imem_req        = reset & req_c;
    assign imem_addr       = reset ? pc : 32'h0;
    assign pc_out          = reset ? pc : 32'h0;
    assign fetch_valid     = reset & valid_c;
    assign instruction_out = fetch_valid ? instr_c : 32'h0;
    assign pc_plus_4_out   = fetch_valid ? pc_inc(pc) : 32'h0;

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= 32'h0;
            perf_wait_cnt  <= 32'h0;
        end else begin
            if (fetch_valid)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (imem_req && !imem_ack)
                perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a wait-state-programmable memory model (word = addr ^ mask).
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus_4_out;
    logic [31:0] instruction_out;
    logic        fetch_valid;
    logic [31:0] pc_out;

    logic        tie0 = 1'b0;
    logic [31:0] tie0_32 = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] pp4_2;
    logic [31:0] instr2;
    logic        valid2;
    logic [31:0] pc2;

    int          waits = 0;
    int          wait_cnt;
    logic [31:0] mask = 32'h0;
    int          checks = 0;
    int          failures = 0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_wait_cnt;
    logic [31:0] perf_fetch_cnt2, perf_wait_cnt2;
`endif

    always #5 clk = ~clk;

    assign imem_ack   = imem_req && (wait_cnt >= waits);
    assign imem_rdata = imem_ack ? (imem_addr ^ mask) : 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt <= 0;
        else if (imem_req && !imem_ack)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_plus_4_out(pc_plus_4_out), .instruction_out(instruction_out),
        .fetch_valid(fetch_valid), .pc_out(pc_out)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset), .stall(tie0), .flush(tie0),
        .branch_target(tie0_32),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(req2), .imem_rdata(addr2),
        .pc_plus_4_out(pp4_2), .instruction_out(instr2),
        .fetch_valid(valid2), .pc_out(pc2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt2), .perf_wait_cnt(perf_wait_cnt2)
`endif
    );

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        branch_target = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        waits = 0;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", fetch_valid); end
        checks++; if (instruction_out !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instruction_out); end
        checks++; if (pc_plus_4_out !== 32'h0) begin failures++; $display("FAIL rst_pp4 got=%h exp=0", pc_plus_4_out); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    endtask

    task automatic test_zero_wait();
        mask = 32'h0;
        waits = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL zw_valid c%0d got=%b exp=1", i, fetch_valid); end
            checks++; if (pc_plus_4_out !== 32'(4 * (i + 1))) begin failures++; $display("FAIL zw_pp4 c%0d got=%h exp=%h", i, pc_plus_4_out, 32'(4 * (i + 1))); end
            checks++; if (instruction_out !== 32'(4 * i)) begin failures++; $display("FAIL zw_instr c%0d got=%h exp=%h", i, instruction_out, 32'(4 * i)); end
        end
    endtask

    task automatic test_wait2();
        logic [31:0] exp_addr;
        logic        exp_valid;
        mask = 32'h0;
        waits = 2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_addr  = (i < 3) ? 32'h0 : 32'h4;
            exp_valid = (i == 2);
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL w2_req c%0d got=%b exp=1", i, imem_req); end
            checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL w2_addr c%0d got=%h exp=%h", i, imem_addr, exp_addr); end
            checks++; if (fetch_valid !== exp_valid) begin failures++; $display("FAIL w2_valid c%0d got=%b exp=%b", i, fetch_valid, exp_valid); end
            checks++; if (pc_plus_4_out !== (exp_valid ? 32'h4 : 32'h0)) begin failures++; $display("FAIL w2_pp4 c%0d got=%h", i, pc_plus_4_out); end
        end
    endtask

    task automatic test_mid_reset();
        waits = 2;
        do_reset();
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mr_req_pre got=%b exp=1", imem_req); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mr_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mr_addr got=%h exp=0", imem_addr); end
        waits = 0;
        do_reset();
        #1;
        checks++; if (fetch_valid !== 1'b1 || pc_plus_4_out !== 32'h4) begin failures++; $display("FAIL mr_after got=%b/%h exp=1/00000004", fetch_valid, pc_plus_4_out); end
    endtask

    task automatic test_stall();
        logic        exp_req, exp_valid;
        logic [31:0] pcv, exp_instr, exp_pp4;
        mask = 32'hDEAD_0000;
        waits = 0;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            stall = (c >= 5 && c <= 7);
            #1;
            exp_req   = !(c >= 6 && c <= 8);
            exp_valid = !(c >= 5 && c <= 7);
            pcv       = (c <= 4) ? 32'(4 * (c - 1)) : ((c == 8) ? 32'h10 : 32'h14);
            exp_instr = exp_valid ? (pcv ^ 32'hDEAD_0000) : 32'h0;
            exp_pp4   = exp_valid ? pcv + 32'd4 : 32'h0;
            checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL st_req c%0d got=%b exp=%b", c, imem_req, exp_req); end
            checks++; if (fetch_valid !== exp_valid) begin failures++; $display("FAIL st_valid c%0d got=%b exp=%b", c, fetch_valid, exp_valid); end
            checks++; if (instruction_out !== exp_instr) begin failures++; $display("FAIL st_instr c%0d got=%h exp=%h", c, instruction_out, exp_instr); end
            checks++; if (pc_plus_4_out !== exp_pp4) begin failures++; $display("FAIL st_pp4 c%0d got=%h exp=%h", c, pc_plus_4_out, exp_pp4); end
        end
        stall = 1'b0;
    endtask

    task automatic test_flush_drain();
        logic [31:0] exp_addr;
        logic        exp_valid;
        mask = 32'h5A00_0000;
        waits = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 9) begin
                waits = 2;
                flush = 1'b1;
                branch_target = 32'h100;
            end else begin
                flush = 1'b0;
            end
            #1;
            if (c <= 8) exp_addr = 32'(4 * (c - 1));
            else if (c <= 11) exp_addr = 32'h20;
            else exp_addr = 32'h100;
            exp_valid = (c <= 8) || (c == 14);
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL fd_req c%0d got=%b exp=1", c, imem_req); end
            checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL fd_addr c%0d got=%h exp=%h", c, imem_addr, exp_addr); end
            checks++; if (fetch_valid !== exp_valid) begin failures++; $display("FAIL fd_valid c%0d got=%b exp=%b", c, fetch_valid, exp_valid); end
            checks++; if (instruction_out !== (exp_valid ? (exp_addr ^ 32'h5A00_0000) : 32'h0)) begin failures++; $display("FAIL fd_instr c%0d got=%h", c, instruction_out); end
        end
        checks++; if (pc_plus_4_out !== 32'h104) begin failures++; $display("FAIL fd_pp4 got=%h exp=00000104", pc_plus_4_out); end
    endtask

    task automatic test_flush_hold();
        mask = 32'h0BAD_0000;
        waits = 0;
        do_reset();
        stall = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL fh_c1_valid got=%b exp=0", fetch_valid); end
        @(negedge clk);
        flush = 1'b1;
        branch_target = 32'h201;
        #1;
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL fh_c2 got req=%b valid=%b exp=0/0", imem_req, fetch_valid); end
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL fh_addr got=%h exp=00000200", imem_addr); end
        checks++; if (fetch_valid !== 1'b1 || pc_plus_4_out !== 32'h204) begin failures++; $display("FAIL fh_deliver got=%b/%h exp=1/00000204", fetch_valid, pc_plus_4_out); end
        checks++; if (instruction_out !== 32'h0BAD_0200) begin failures++; $display("FAIL fh_instr got=%h exp=0bad0200", instruction_out); end
        @(negedge clk);
        flush = 1'b1;
        branch_target = 32'h40;
        #1;
        checks++; if (fetch_valid !== 1'b0 || instruction_out !== 32'h0 || pc_plus_4_out !== 32'h0) begin failures++; $display("FAIL fa_nop got=%b/%h/%h exp=0/0/0", fetch_valid, instruction_out, pc_plus_4_out); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h40 || pc_plus_4_out !== 32'h44) begin failures++; $display("FAIL fa_redirect got=%h/%h exp=00000040/00000044", imem_addr, pc_plus_4_out); end
    endtask

    task automatic test_reset_pc_wrap();
        waits = 0;
        do_reset();
        #1;
        checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_addr0 got=%h exp=fffffffc", addr2); end
        checks++; if (valid2 !== 1'b1 || pp4_2 !== 32'h0) begin failures++; $display("FAIL wr_pp4 got=%b/%h exp=1/00000000", valid2, pp4_2); end
        checks++; if (instr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_instr got=%h exp=fffffffc", instr2); end
        @(negedge clk);
        #1;
        checks++; if (addr2 !== 32'h0 || pp4_2 !== 32'h4) begin failures++; $display("FAIL wr_next got=%h/%h exp=0/00000004", addr2, pp4_2); end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        mask = 32'h0;
        waits = 0;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 11) waits = 5;
        end
        @(negedge clk);
        #1;
        checks++; if (perf_fetch_cnt !== 32'd10) begin failures++; $display("FAIL perf_fetch got=%0d exp=10", perf_fetch_cnt); end
        checks++; if (perf_wait_cnt !== 32'd4) begin failures++; $display("FAIL perf_wait got=%0d exp=4", perf_wait_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_mid_reset();
        test_stall();
        test_flush_drain();
        test_flush_hold();
        test_reset_pc_wrap();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
